rx: RTL and testbench

RX -- requirements
Module: rx

---
 rtl/rx.sv | 120 ++++++++++++
 tb/tb_rx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rx.sv
// UART-style serial receiver: 2-flop synchronizer, start-edge detect, mid-bit
// sampling of WIDTH data bits (MSB first) and one stop bit.
module rx #(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RXD,
  output logic [WIDTH-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             RX_ERR,
  output logic             RX_BUSY,
  output logic [1:0]       dbg_state
);

  localparam int CW   = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW   = $clog2(WIDTH + 1);
  localparam int HALF = OVERSAMPLE / 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [BW-1:0]    bit_cnt, bit_next;
  logic [WIDTH-1:0] shift, shift_next;
  logic [WIDTH-1:0] data_next;
  logic             valid_next, err_next;
  logic             sync1, rxs, rxs_q;

  // rxs_q is the previous synchronized value, used only for edge detection.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      sync1 <= RXD;
      rxs   <= sync1;
      rxs_q <= rxs;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      RX_ERR   <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      bit_cnt  <= bit_next;
      shift    <= shift_next;
      RX_DATA  <= data_next;
      RX_VALID <= valid_next;
      RX_ERR   <= err_next;
    end
  end

  // cnt is cleared at each sample point, so it reads j-1 on the j-th cycle after it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CW'(1);
    bit_next   = bit_cnt;
    shift_next = shift;
    data_next  = RX_DATA;
    valid_next = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        bit_next = '0;
        if (!rxs && rxs_q) state_next = START;
      end
      START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_next   = '0;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CW'(OVERSAMPLE - 1)) begin
          cnt_next   = '0;
          shift_next = {shift[WIDTH-2:0], rxs};
          if (bit_cnt == BW'(WIDTH - 1)) begin
            bit_next   = '0;
            state_next = STOP;
          end else begin
            bit_next = bit_cnt + BW'(1);
          end
        end
      end
      STOP: begin
        if (cnt == CW'(OVERSAMPLE - 1)) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (rxs) begin
            valid_next = 1'b1;
            data_next  = shift;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
        bit_next   = '0;
      end
    endcase
  end

  assign RX_BUSY   = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_rx.sv
// Bench for rx: directed frames plus randomized frames with mid-bit glitches,
// checked against frame-level expectations (sent words, pulse time E+153).
module tb_rx;
  localparam int W    = 8;
  localparam int OS   = 16;
  localparam int HMAX = 16384;
  localparam int LAT  = OS / 2 + (W + 1) * OS + 1;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         RXD = 1'b1;
  logic [W-1:0] RX_DATA;
  logic         RX_VALID, RX_ERR, RX_BUSY;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit           valid_h[HMAX];
  bit           err_h[HMAX];
  bit           busy_h[HMAX];
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];

  rx #(.WIDTH(W), .OVERSAMPLE(OS)) dut (
    .CLK(CLK), .RST(RST), .RXD(RXD),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_ERR(RX_ERR),
    .RX_BUSY(RX_BUSY), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (cyc < HMAX) begin
      valid_h[cyc] = RX_VALID;
      err_h[cyc]   = RX_ERR;
      busy_h[cyc]  = RX_BUSY;
    end
    if (RX_VALID) got_q.push_back(RX_DATA);
  end

  function automatic int n_valid(int a, int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (i < HMAX && valid_h[i]) n++;
    return n;
  endfunction

  function automatic int n_err(int a, int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (i < HMAX && err_h[i]) n++;
    return n;
  endfunction

  function automatic int n_busy(int a, int b);
    int n = 0;
    for (int i = a; i <= b; i++) if (i < HMAX && busy_h[i]) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_data(input string tag, input logic [W-1:0] exp_v);
    logic [W-1:0] v;
    v = 'x;
    if (got_q.size() > 0) v = got_q.pop_front();
    chk(tag, 32'(v), 32'(exp_v));
  endtask

  task automatic drive(input logic v, input int c);
    RXD = v;
    repeat (c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // e is the cycle at which the synchronized line first shows the start bit.
  task automatic send_frame(input logic [W-1:0] d, input logic stop, input int per,
                            input bit glitch, output int e);
    logic [W+1:0] bits;
    bits = {1'b0, d, stop};
    e = cyc + 2;
    for (int i = W + 1; i >= 0; i--) begin
      if (glitch) begin
        drive(bits[i], 3);
        drive(~bits[i], 2);
        drive(bits[i], per - 5);
      end else begin
        drive(bits[i], per);
      end
    end
  endtask

  initial begin
    int e, e2, r0, exp_err, gap, bad;
    logic [W-1:0] d;
    logic stop;
    bit gl;
    int pers[2];
    pers[0] = 15;
    pers[1] = 17;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_data", 32'(RX_DATA), 32'h0);
    chk("rst_valid", 32'(RX_VALID), 32'h0);
    chk("rst_err", 32'(RX_ERR), 32'h0);
    chk("rst_busy", 32'(RX_BUSY), 32'h0);
    RST = 1'b0;
    drive(1'b1, 10);

    send_frame(8'hA5, 1'b1, OS, 1'b0, e);
    drive(1'b1, 10);
    chk("a5_valid_at", 32'(valid_h[e+LAT]), 32'h1);
    chk("a5_pulses", n_valid(e, e + LAT + 15), 1);
    chk("a5_busy_e", 32'(busy_h[e]), 32'h0);
    chk("a5_busy_e1", 32'(busy_h[e+1]), 32'h1);
    chk("a5_busy_span", n_busy(e + 1, e + LAT - 1), LAT - 1);
    chk("a5_busy_end", 32'(busy_h[e+LAT]), 32'h0);
    chk_data("a5_data", 8'hA5);

    send_frame(8'h00, 1'b1, OS, 1'b0, e);
    send_frame(8'hFF, 1'b1, OS, 1'b0, e2);
    drive(1'b1, 10);
    chk("b2b_first_at", 32'(valid_h[e+LAT]), 32'h1);
    chk("b2b_second_at", 32'(valid_h[e+LAT+160]), 32'h1);
    chk("b2b_pulses", n_valid(e, e2 + LAT + 5), 2);
    chk_data("b2b_data0", 8'h00);
    chk_data("b2b_data1", 8'hFF);

    send_frame(8'h3C, 1'b0, OS, 1'b0, e);
    drive(1'b0, 300);
    drive(1'b1, 20);
    chk("ferr_at", 32'(err_h[e+LAT]), 32'h1);
    chk("ferr_pulses", n_err(e, e + LAT + 330), 1);
    chk("ferr_no_valid", n_valid(e, e + LAT + 330), 0);
    chk("ferr_data_kept", 32'(RX_DATA), 32'hFF);
    chk("ferr_low_idle", n_busy(e + LAT, e + LAT + 320), 0);

    e = cyc + 2;
    drive(1'b0, 4);
    drive(1'b1, 40);
    chk("fs_busy_span", n_busy(e + 1, e + 8), 8);
    chk("fs_busy_low", 32'(busy_h[e+9]), 32'h0);
    chk("fs_no_pulse", n_valid(e, e + 40) + n_err(e, e + 40), 0);
    send_frame(8'h81, 1'b1, OS, 1'b0, e);
    drive(1'b1, 10);
    chk("fs_next_at", 32'(valid_h[e+LAT]), 32'h1);
    chk_data("fs_next_data", 8'h81);

    e = cyc + 2;
    drive(1'b0, 16);
    drive(1'b0, 16);
    drive(1'b1, 16);
    drive(1'b0, 14);
    RST = 1'b1;
    #1;
    chk("mrst_busy", 32'(RX_BUSY), 32'h0);
    chk("mrst_data", 32'(RX_DATA), 32'h0);
    chk("mrst_valid", 32'(RX_VALID), 32'h0);
    chk("mrst_err", 32'(RX_ERR), 32'h0);
    drive(1'b1, 20);
    RST = 1'b0;
    drive(1'b1, 20);
    chk("mrst_no_pulse", n_valid(e, cyc - 1) + n_err(e, cyc - 1), 0);
    send_frame(8'h12, 1'b1, OS, 1'b0, e);
    drive(1'b1, 10);
    chk("mrst_next_at", 32'(valid_h[e+LAT]), 32'h1);
    chk_data("mrst_next_data", 8'h12);

    for (int p = 0; p < 2; p++) begin
      send_frame(8'hC3, 1'b1, pers[p], 1'b0, e);
      drive(1'b1, 30);
      chk("skew_no_err", n_err(e, cyc - 1), 0);
      chk("skew_pulses", n_valid(e, cyc - 1), 1);
      chk_data("skew_data", 8'hC3);
    end

    r0 = cyc;
    exp_err = 0;
    for (int k = 0; k < 40; k++) begin
      d    = W'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      gl   = bit'($urandom_range(0, 1));
      send_frame(d, stop, OS, gl, e);
      if (stop) exp_q.push_back(d);
      else exp_err++;
      chk("rnd_pulse_at", stop ? 32'(valid_h[e+LAT]) : 32'(err_h[e+LAT]), 32'h1);
      gap = stop ? $urandom_range(0, 12) : $urandom_range(2, 12);
      if (gap > 0) drive(1'b1, gap);
    end
    drive(1'b1, 20);
    chk("rnd_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) chk_data("rnd_data", exp_q.pop_front());
    chk("rnd_errs", n_err(r0, cyc - 1), exp_err);

    bad = 0;
    for (int i = 0; i < cyc - 1 && i < HMAX - 1; i++) begin
      if ((valid_h[i] && err_h[i]) || (valid_h[i] && valid_h[i+1]) || (err_h[i] && err_h[i+1]))
        bad++;
    end
    chk("pulse_rules", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
